bus_master_port: RTL
====================

# bus_master_port

Registered bus-master front end sitting directly upstream of the bus interconnect: accepts single-word load/store requests from the CPU memory stage, drives the interconnect's master strobe/write/address/data inputs, waits for the selected slave's acknowledge, and returns read data plus a one-cycle completion pulse. Bus faults are converted to an error completion so the CPU never hangs: decode misses reported by the interconnect, and optionally a slave that never acknowledges.

## Interface
- TIMEOUT, 256: cycles a strobe may stay unacknowledged before an error completion; legal range 1..65535.
- clk_i  in  1  system clock; all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- req_i  in  1  CPU request valid; sampled only when accepting (see Operation)
- we_i  in  1  1 = store, 0 = load
- adr_i  in  32  word address
- dat_i  in  32  store data
- rdata_o  out  32  load data; valid while done_o=1, held until the next load completes
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  qualifies done_o; 1 = faulted transaction
- busy_o  out  1  transaction outstanding; request not accepted
- bus_stb_o  out  1  to interconnect master strobe
- bus_we_o  out  1  to interconnect master write enable
- bus_adr_o  out  32  to interconnect master address
- bus_dat_o  out  32  to interconnect master write data
- bus_dat_i  in  32  interconnect read data
- bus_ack_i  in  1  interconnect acknowledge
- bus_adr_err_i  in  1  interconnect decode miss

## Operation
- States: IDLE, REQ, RESP. Reset state IDLE.
- Accept: in IDLE or RESP with req_i=1, capture we_i/adr_i/dat_i into bus_*_o registers and go to REQ; otherwise go to IDLE.
- REQ: bus_stb_o=1, busy_o=1, request registers frozen; req_i ignored.
- Per cycle in REQ, priority: bus_adr_err_i=1 -> RESP with error; else bus_ack_i=1 -> RESP OK, loads capture bus_dat_i into rdata_o; else timeout expiry -> RESP with error; else stay.
- Simultaneous ack and timeout expiry: ack wins. Simultaneous ack and adr_err: adr_err wins.
- RESP: done_o=1, err_o=1 iff faulted; bus_stb_o=0, busy_o=0. Lasts exactly one cycle.
- Stores leave rdata_o unchanged. A faulted load drives rdata_o to 32'h0.
- bus_we_o/bus_adr_o/bus_dat_o hold their last captured values outside REQ; slaves qualify them with cs only.

## Timing
- Reset values: rdata_o=0, done_o=0, err_o=0, busy_o=0, bus_stb_o=0, bus_we_o=0, bus_adr_o=0, bus_dat_o=0, timeout counter=0.
- All outputs are registered. No combinational path from bus_ack_i or bus_dat_i to any output.
- Latency: a request accepted in cycle N raises strobe in N+1. With ack in N+1, done_o pulses in N+2.
- Back-to-back: req_i=1 during the RESP cycle starts the next strobe in the following cycle; sustained throughput is one transaction per 2 cycles.
- Timeout: the counter clears on entry to REQ and increments each REQ cycle without ack/adr_err. Expiry is counter==TIMEOUT-1 with no ack. Counter width is $clog2(TIMEOUT).
- Reset mid-transaction: strobe drops immediately (asynchronous), no done_o, the transaction is lost.

## Configuration
- BUS_MASTER_TIMEOUT_EN defined: the timeout counter and the expiry error path are present.
- Undefined: no counter. REQ waits indefinitely for ack or adr_err, and TIMEOUT is ignored.

## Structure
- Shared bus_pkg holds: the state encoding (IDLE/RESP/REQ constants), the default TIMEOUT, the bus data/address width constants, and the error read value 32'h0.
- One sub-module, bus_timeout_counter: clear/enable/expire, parameterised by TIMEOUT, instantiated only under BUS_MASTER_TIMEOUT_EN.
- The FSM and request/response registers are in the top module.

## Test plan
- Load, slave acks in the first strobe cycle with 32'hDEADBEEF: stb high 1 cycle, done_o=1/err_o=0 two cycles after the request, rdata_o=32'hDEADBEEF.
- Store adr 32'h0000_1000, dat 32'h1234_5678, ack after 3 wait cycles: bus_we_o=1, address and data stable for all 4 strobe cycles, rdata_o unchanged.
- adr_err_i=1 in the first strobe cycle of a load: done_o=1, err_o=1, rdata_o=0. Repeat with ack asserted simultaneously: still an error.
- TIMEOUT=4, macro defined, no ack: done_o/err_o pulse after 4 strobe cycles. Ack on the 4th cycle gives an OK completion. Without the macro, strobe stays high for 100 cycles.
- Back-to-back loads with req_i held high: strobes in cycles 1, 3 and 5, done pulses in 2, 4 and 6. Requests presented while busy_o=1 are not captured.
- rst_i low during the strobe: bus_stb_o=0 without waiting for a clock edge, no done_o. The first request after reset completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus master front end: FSM encoding, bus widths,
// default strobe timeout and the read value returned on a faulted load.
package bus_pkg;

    localparam int BUS_AW              = 32;
    localparam int BUS_DW              = 32;
    localparam int BUS_TIMEOUT_DEFAULT = 256;

    localparam logic [BUS_DW-1:0] BUS_ERR_RDATA = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } bus_state_e;

    // A one-cycle timeout still needs a one-bit counter.
    function automatic int timeout_cnt_w(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/bus_master_port_if.sv
// Interconnect-side master signals of bus_master_port; master modport faces
// the port, slave modport faces the interconnect (or a bench model of it).
interface bus_master_port_if;
    import bus_pkg::*;

    logic              bus_stb_o;
    logic              bus_we_o;
    logic [BUS_AW-1:0] bus_adr_o;
    logic [BUS_DW-1:0] bus_dat_o;
    logic [BUS_DW-1:0] bus_dat_i;
    logic              bus_ack_i;
    logic              bus_adr_err_i;

    modport master (
        output bus_stb_o, bus_we_o, bus_adr_o, bus_dat_o,
        input  bus_dat_i, bus_ack_i, bus_adr_err_i
    );

    modport slave (
        input  bus_stb_o, bus_we_o, bus_adr_o, bus_dat_o,
        output bus_dat_i, bus_ack_i, bus_adr_err_i
    );

endinterface

// File: rtl/bus_timeout_counter.sv
// Strobe watchdog: cleared when a request is accepted, counts unacknowledged
// strobe cycles, and flags expiry on the TIMEOUT-th such cycle.
module bus_timeout_counter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int               CNT_W    = timeout_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign expire = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/bus_master_port.sv
// Registered single-word bus master between the CPU memory stage and the
// interconnect. Optional strobe timeout enabled by BUS_MASTER_TIMEOUT_EN.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [BUS_AW-1:0] adr_i,
    input  logic [BUS_DW-1:0] dat_i,
    output logic [BUS_DW-1:0] rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic              busy_o,
    bus_master_port_if.master bus
);

    bus_state_e        state_reg, state_next;
    logic              stb_reg, stb_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              we_reg, we_next;
    logic [BUS_AW-1:0] adr_reg, adr_next;
    logic [BUS_DW-1:0] dat_reg, dat_next;
    logic [BUS_DW-1:0] rdata_reg, rdata_next;
    logic              cnt_clear, cnt_enable, timeout_expire;

`ifdef BUS_MASTER_TIMEOUT_EN
    bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expire (timeout_expire)
    );
`else
    // Without the watchdog a strobe waits for ack or decode miss forever.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0) ^ cnt_clear ^ cnt_enable;
    assign timeout_expire = 1'b0;
`endif

    always_comb begin
        state_next = ST_IDLE;
        stb_next   = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        we_next    = we_reg;
        adr_next   = adr_reg;
        dat_next   = dat_reg;
        rdata_next = rdata_reg;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        case (state_reg)
            ST_REQ: begin
                // Decode miss beats ack, ack beats the watchdog.
                if (bus.bus_adr_err_i) begin
                    state_next = ST_RESP;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                    if (!we_reg) rdata_next = BUS_ERR_RDATA;
                end else if (bus.bus_ack_i) begin
                    state_next = ST_RESP;
                    done_next  = 1'b1;
                    if (!we_reg) rdata_next = bus.bus_dat_i;
                end else if (timeout_expire) begin
                    state_next = ST_RESP;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                    if (!we_reg) rdata_next = BUS_ERR_RDATA;
                end else begin
                    state_next = ST_REQ;
                    stb_next   = 1'b1;
                    cnt_enable = 1'b1;
                end
            end
            default: begin
                // IDLE and RESP both accept, giving one transaction per 2 cycles.
                if (req_i) begin
                    state_next = ST_REQ;
                    stb_next   = 1'b1;
                    we_next    = we_i;
                    adr_next   = adr_i;
                    dat_next   = dat_i;
                    cnt_clear  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
            stb_reg   <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            we_reg    <= 1'b0;
            adr_reg   <= '0;
            dat_reg   <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            stb_reg   <= stb_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            we_reg    <= we_next;
            adr_reg   <= adr_next;
            dat_reg   <= dat_next;
            rdata_reg <= rdata_next;
        end
    end

    assign bus.bus_stb_o = stb_reg;
    assign bus.bus_we_o  = we_reg;
    assign bus.bus_adr_o = adr_reg;
    assign bus.bus_dat_o = dat_reg;
    assign busy_o        = stb_reg;
    assign done_o        = done_reg;
    assign err_o         = err_reg;
    assign rdata_o       = rdata_reg;

endmodule
